// File: rtl/reg_bank_sb.sv
// 2-read/1-write register bank with per-register busy scoreboard and a
// one-register-per-cycle clear sequence after reset.
module reg_bank_sb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             issue,
  input  logic [AW-1:0]    issue_dr,
  output logic             busy_1,
  output logic             busy_2,
  output logic             ready
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_en;
  logic iss_en;
  logic hit_1;
  logic hit_2;

  // Register 0 is hardwired when ZERO_R0, so it never takes data or a producer.
  assign wr_en  = write && (state == RUN) && !(ZERO_R0 && (dr == '0));
  assign iss_en = issue && (state == RUN) && !(ZERO_R0 && (issue_dr == '0));
  assign hit_1  = BYPASS && wr_en && (dr == sr1);
  assign hit_2  = BYPASS && wr_en && (dr == sr2);

  // Clear sequencer and run-time write/issue; issue after write so issue wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (wr_en) begin
            regs[dr] <= write_data;
            busy[dr] <= 1'b0;
          end
          if (iss_en) begin
            busy[issue_dr] <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    read_data_1 = '0;
    busy_1      = 1'b0;
    if ((state == RUN) && !(ZERO_R0 && (sr1 == '0))) begin
      if (hit_1) begin
        read_data_1 = write_data;
      end else begin
        read_data_1 = regs[sr1];
        busy_1      = busy[sr1];
      end
    end
  end

  always_comb begin
    read_data_2 = '0;
    busy_2      = 1'b0;
    if ((state == RUN) && !(ZERO_R0 && (sr2 == '0))) begin
      if (hit_2) begin
        read_data_2 = write_data;
      end else begin
        read_data_2 = regs[sr2];
        busy_2      = busy[sr2];
      end
    end
  end

endmodule
